vending_machine_top: RTL and testbench

//   Coin-switch soda vending machine top level for the FPGA board. Five nickel switches and three

---
 rtl/vending_pkg.sv | 50 +++++
 rtl/vending_machine_seg7_scan.sv | 61 ++++++
 rtl/vending_machine_top.sv | 96 +++++++++
 tb/tb_vending_machine_top.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared constants and helpers for the coin-switch vending machine.
package vending_pkg;

  localparam int NICKEL_CENTS        = 5;
  localparam int DIME_CENTS          = 10;
  localparam int DEFAULT_PRICE_CENTS = 25;
  localparam int NUM_NICKELS         = 5;
  localparam int NUM_DIMES           = 3;

  // Active-low 7-segment pattern, bit 0 = segment a ... bit 6 = segment g.
  function automatic logic [6:0] seg7_glyph(input logic [3:0] bcd);
    logic [6:0] g;
    case (bcd)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  // Two-digit BCD of a 0..55 value using a comparator chain instead of a divider.
  // Returns {tens, units}.
  function automatic logic [7:0] to_bcd2(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    if (v >= 6'd50) begin
      tens = 4'd5; rem = v - 6'd50;
    end else if (v >= 6'd40) begin
      tens = 4'd4; rem = v - 6'd40;
    end else if (v >= 6'd30) begin
      tens = 4'd3; rem = v - 6'd30;
    end else if (v >= 6'd20) begin
      tens = 4'd2; rem = v - 6'd20;
    end else if (v >= 6'd10) begin
      tens = 4'd1; rem = v - 6'd10;
    end else begin
      tens = 4'd0; rem = v;
    end
    return {tens, rem[3:0]};
  endfunction

endpackage

// File: rtl/vending_machine_seg7_scan.sv
// Multiplexed 4-digit 7-segment driver: scan counter, digit mux and output registers.
module seg7_scan
  import vending_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit3,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  output logic [3:0] seg_an,
  output logic [6:0] seg_cat
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] scan_cnt_reg;
  logic [1:0]    digit_idx_reg;
  logic [3:0]    digit_sel;

  // Dwell counter: each digit stays lit SCAN_DIV cycles before the index advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_reg  <= '0;
      digit_idx_reg <= '0;
    end else if (scan_cnt_reg == CNT_LAST) begin
      scan_cnt_reg  <= '0;
      digit_idx_reg <= digit_idx_reg + 2'd1;
    end else begin
      scan_cnt_reg  <= scan_cnt_reg + CW'(1);
    end
  end

  // Pick the BCD value for the digit currently being driven.
  always_comb begin
    digit_sel = digit0;
    case (digit_idx_reg)
      2'd0: digit_sel = digit0;
      2'd1: digit_sel = digit1;
      2'd2: digit_sel = digit2;
      2'd3: digit_sel = digit3;
      default: digit_sel = digit0;
    endcase
  end

  // Anode and cathode registered together so the glyph always matches the lit digit;
  // data is resampled every cycle so credit changes show up on the current digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_an  <= 4'b1111;
      seg_cat <= 7'b1111111;
    end else begin
      seg_an  <= ~(4'b0001 << digit_idx_reg);
      seg_cat <= seg7_glyph(digit_sel);
    end
  end

endmodule

// File: rtl/vending_machine_top.sv
// Level-based coin-switch vending machine: synchronise switches, sum credit,
// compare against the price and show credit/change on a 4-digit display.
module vending_machine_top
  import vending_pkg::*;
#(
  parameter int PRICE_CENTS = DEFAULT_PRICE_CENTS,
  parameter int SCAN_DIV    = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       n0,
  input  logic       n1,
  input  logic       n2,
  input  logic       n3,
  input  logic       n4,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  output logic [3:0] seg_an,
  output logic [6:0] seg_cat,
  output logic       soda_led,
  output logic       change_led
);

  localparam logic [5:0] PRICE = 6'(PRICE_CENTS);

  // Bits [4:0] are nickels, [7:5] are dimes.
  logic [7:0] sw_raw;
  logic [7:0] sync1_reg;
  logic [7:0] sync2_reg;
  logic [5:0] credit_next;
  logic [5:0] change_next;
  logic       soda_next;
  logic       over_next;
  logic [5:0] credit_reg;
  logic [5:0] change_reg;
  logic [7:0] credit_bcd;
  logic [7:0] change_bcd;

  assign sw_raw = {d2, d1, d0, n4, n3, n2, n1, n0};

  // Two-flop synchroniser for the asynchronous switch levels (no debounce).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= sw_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Credit is the value of coins currently present, plus price comparisons and change.
  always_comb begin
    credit_next = '0;
    for (int i = 0; i < NUM_NICKELS; i++)
      if (sync2_reg[i]) credit_next = credit_next + 6'(NICKEL_CENTS);
    for (int i = 0; i < NUM_DIMES; i++)
      if (sync2_reg[NUM_NICKELS + i]) credit_next = credit_next + 6'(DIME_CENTS);
    soda_next   = (credit_next >= PRICE);
    over_next   = (credit_next >  PRICE);
    change_next = soda_next ? (credit_next - PRICE) : 6'd0;
  end

  // Credit and vend decisions registered together, one cycle after the synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_reg <= '0;
      change_reg <= '0;
      soda_led   <= 1'b0;
      change_led <= 1'b0;
    end else begin
      credit_reg <= credit_next;
      change_reg <= change_next;
      soda_led   <= soda_next;
      change_led <= over_next;
    end
  end

  assign credit_bcd = to_bcd2(credit_reg);
  assign change_bcd = to_bcd2(change_reg);

  seg7_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk    (clk),
    .rst_n  (rst_n),
    .digit3 (credit_bcd[7:4]),
    .digit2 (credit_bcd[3:0]),
    .digit1 (change_bcd[7:4]),
    .digit0 (change_bcd[3:0]),
    .seg_an (seg_an),
    .seg_cat(seg_cat)
  );

endmodule

// File: tb/tb_vending_machine_top.sv
// Self-checking bench for vending_machine_top: vector table, random patterns, reset corner cases.
module tb_vending_machine_top;

  localparam int SCAN_DIV = 4;
  localparam int PRICE    = 25;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] n_sw = '0;
  logic [2:0] d_sw = '0;
  logic [3:0] seg_an;
  logic [6:0] seg_cat;
  logic       soda_led;
  logic       change_led;

  int vectors = 0;
  int miscompares = 0;
  logic armed = 1'b0;
  logic prev_soda = 1'b0;
  logic prev_change = 1'b0;

  typedef struct {
    logic [4:0]  n;
    logic [2:0]  d;
    logic        soda;
    logic        change;
    logic [15:0] disp;   // BCD nibbles, [15:12] = leftmost digit
  } vec_t;

  vec_t tab[9];

  vending_machine_top #(.PRICE_CENTS(PRICE), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .n0(n_sw[0]), .n1(n_sw[1]), .n2(n_sw[2]), .n3(n_sw[3]), .n4(n_sw[4]),
    .d0(d_sw[0]), .d1(d_sw[1]), .d2(d_sw[2]),
    .seg_an(seg_an), .seg_cat(seg_cat), .soda_led(soda_led), .change_led(change_led)
  );

  always #10 clk = ~clk;

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference model: value of the coins present, vend rules and decimal display.
  task automatic model(input logic [4:0] n, input logic [2:0] d,
                       output logic soda, output logic change, output logic [15:0] disp);
    int credit, chg;
    credit = 5 * $countones(n) + 10 * $countones(d);
    soda   = (credit >= PRICE);
    change = (credit > PRICE);
    chg    = soda ? credit - PRICE : 0;
    disp   = {4'(credit / 10), 4'(credit % 10), 4'(chg / 10), 4'(chg % 10)};
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive switches at a falling edge; vend LEDs must hold for two edges and change on the third.
  task automatic apply(input string name, input logic [4:0] n, input logic [2:0] d,
                       input logic soda, input logic change);
    @(negedge clk);
    n_sw = n;
    d_sw = d;
    @(posedge clk); @(posedge clk); #1;
    check1({name, "_soda_hold"}, soda_led, prev_soda);
    check1({name, "_change_hold"}, change_led, prev_change);
    @(posedge clk); #1;
    check1({name, "_soda"}, soda_led, soda);
    check1({name, "_change"}, change_led, change);
    prev_soda   = soda;
    prev_change = change;
    $display("vec %s: n=%b d=%b soda=%b change=%b", name, n, d, soda_led, change_led);
  endtask

  // Watch a full rotation and more; every lit digit must show its expected glyph.
  task automatic check_display(input string name, input logic [15:0] disp);
    logic [6:0] got[4];
    logic [3:0] seen;
    logic       bad;
    int         idx;
    seen = '0;
    bad  = 1'b0;
    for (int i = 0; i < 4; i++) got[i] = 7'h7f;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4 * SCAN_DIV + 4; k++) begin
      @(negedge clk);
      case (seg_an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx >= 0) begin
        seen[idx] = 1'b1;
        got[idx]  = seg_cat;
        if (seg_cat !== glyph(int'(disp[idx*4 +: 4]))) bad = 1'b1;
      end
    end
    vectors++;
    if (bad || seen != 4'hf) begin
      miscompares++;
      $display("FAIL %s_display: got cat %h %h %h %h seen=%b, expected digits %h",
               name, got[3], got[2], got[1], got[0], seen, disp);
    end else begin
      $display("vec %s_display: %h", name, disp);
    end
  endtask

  // Anode one-hot-low check on every active cycle.
  always @(posedge clk) armed <= rst_n;

  always @(negedge clk) begin
    if (rst_n && armed) begin
      vectors++;
      if ($countones(~seg_an) != 1) begin
        miscompares++;
        $display("FAIL anode_onehot: got %b expected exactly one low bit", seg_an);
      end
    end
  end

  initial begin
    logic s, c;
    logic [15:0] dsp;
    logic [4:0] rn;
    logic [2:0] rd;

    tab[0] = '{5'b00000, 3'b000, 1'b0, 1'b0, 16'h0000};
    tab[1] = '{5'b00000, 3'b111, 1'b1, 1'b1, 16'h3005};
    tab[2] = '{5'b00000, 3'b000, 1'b0, 1'b0, 16'h0000};
    tab[3] = '{5'b00001, 3'b111, 1'b1, 1'b1, 16'h3510};
    tab[4] = '{5'b11111, 3'b000, 1'b1, 1'b0, 16'h2500};
    tab[5] = '{5'b00001, 3'b011, 1'b1, 1'b0, 16'h2500};
    tab[6] = '{5'b11111, 3'b111, 1'b1, 1'b1, 16'h5530};
    tab[7] = '{5'b11110, 3'b100, 1'b1, 1'b1, 16'h3005};
    tab[8] = '{5'b11110, 3'b110, 1'b1, 1'b1, 16'h4015};

    // Power-on reset held five cycles.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check1("rst_soda", soda_led, 1'b0);
    check1("rst_change", change_led, 1'b0);
    check1("rst_an", seg_an, 4'b1111);
    check1("rst_cat", seg_cat, 7'b1111111);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check1("first_an", seg_an, 4'b1110);
    check1("first_cat", seg_cat, glyph(0));

    // Table-driven vectors.
    for (int i = 0; i < 9; i++) begin
      apply($sformatf("tab%0d", i), tab[i].n, tab[i].d, tab[i].soda, tab[i].change);
      check_display($sformatf("tab%0d", i), tab[i].disp);
    end

    // Random switch patterns against the reference model.
    for (int i = 0; i < 16; i++) begin
      rn = 5'($urandom);
      rd = 3'($urandom);
      model(rn, rd, s, c, dsp);
      apply($sformatf("rnd%0d", i), rn, rd, s, c);
      check_display($sformatf("rnd%0d", i), dsp);
    end

    // Asynchronous reset mid-scan with every switch set.
    apply("pre_rst", 5'b11111, 3'b111, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check1("async_rst_soda", soda_led, 1'b0);
    check1("async_rst_change", change_led, 1'b0);
    check1("async_rst_an", seg_an, 4'b1111);
    check1("async_rst_cat", seg_cat, 7'b1111111);
    repeat (2) @(negedge clk);
    check1("held_rst_soda", soda_led, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check1("rel_an", seg_an, 4'b1110);
    check1("rel_cat", seg_cat, glyph(0));
    check1("rel_soda_e1", soda_led, 1'b0);
    @(posedge clk); #1;
    check1("rel_soda_e2", soda_led, 1'b0);
    @(posedge clk); #1;
    check1("rel_soda_e3", soda_led, 1'b1);
    check1("rel_change_e3", change_led, 1'b1);
    check_display("post_rst", 16'h5530);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
